mrv32_imm_gen_pipe: RTL and testbench
=====================================

// Module: mrv32_imm_gen_pipe
// PURPOSE
//  Registered, handshaked immediate generator. It sits between the decoder and the issue/execute stage of the pipelined MRV32 core.
//  It builds a sign-extended XLEN immediate from a 32-bit instruction and a format select (I/S/B/U/J, plus CSR Z-imm).
//  Includes a valid/ready pipeline stage with optional 2-entry skid buffer, a flush input and a pass-through tag.
// PARAMETERS
//  XLEN   32  immediate width; legal values 32 or 64; all formats sign-extend from instr[31] to XLEN (Z is zero-extended)
//  TAG_W  5   width of sideband tag carried alongside each immediate (rd/ROB id); legal range >=1
//  SKID   1   1: 2-entry skid buffer, in_ready is a register output; 0: single stage, in_ready = !out_valid | out_ready
// PORTS
//  clk         in   1      clock; all state updates on rising edge
//  rst_n       in   1      synchronous active-low reset
//  flush       in   1      drop all buffered entries (pipeline redirect)
//  in_valid    in   1      upstream entry valid
//  in_ready    out  1      stage can accept; transfer when in_valid & in_ready
//  in_instr    in   32     raw instruction word
//  in_imm_sel  in   3      format: mrv32_pkg IMM_I/IMM_S/IMM_B/IMM_U/IMM_J/IMM_Z
//  in_tag      in   TAG_W  sideband, returned unchanged with the entry
//  out_valid   out  1      output entry valid
//  out_ready   in   1      downstream accepts; transfer when out_valid & out_ready
//  out_imm     out  XLEN   immediate for the head entry
//  out_tag     out  TAG_W  tag for the head entry
//  out_illegal out  1      present only with MRV32_IMM_ILLEGAL_EN; head entry had an undefined imm_sel
// BEHAVIOUR
//  - Formats: I={instr[31:20]}; S={instr[31:25],instr[11:7]}; B={instr[31],instr[7],instr[30:25],instr[11:8],0};
//    U={instr[31:12],12'b0}; J={instr[31],instr[19:12],instr[20],instr[30:21],0}; Z=zext(instr[19:15]).
//  - I/S/B/U/J sign-extend to XLEN, including U when XLEN=64. Undefined sel -> imm 0.
//  - Immediate is computed combinationally from in_* and stored at the accept edge. Buffer stores imm, not instr.
//  - Latency: 1 cycle, accept edge -> out_valid. Back-to-back throughput is 1/cycle when out_ready=1.
//  - Ordering strictly FIFO. No entry is dropped or duplicated except by flush/reset.
//  - SKID=1: states EMPTY(0), ONE(1), FULL(2).
//    - EMPTY: accept -> ONE.
//    - ONE: accept & pop -> ONE; accept only -> FULL; pop only -> EMPTY.
//    - FULL: in_ready=0; pop -> ONE.
//    - in_ready = (state != FULL), taken from a flop.
//  - SKID=0: one register. Simultaneous pop+accept in the same cycle is allowed (in_ready combinationally depends on out_ready).
//  - Simultaneous accept and pop in FULL cannot occur, because in_ready=0.
//  - flush=1: next state EMPTY, out_valid=0, and the in_valid entry of that cycle is discarded.
//    - in_ready=1 during flush cycle (SKID=0) / after it (SKID=1).
//    - flush has priority over accept and pop.
//  - Reset (rst_n=0 at an edge, including mid-stream): out_valid=0, out_imm=0, out_tag=0, out_illegal=0.
//    - State EMPTY; in_ready=1 from the first cycle after reset.
//  - out_imm/out_tag hold their value while out_valid=1 & out_ready=0 (stable under backpressure).
// CONFIGURATION
//  MRV32_IMM_ILLEGAL_EN defined:
//    - out_illegal port exists and is stored per entry.
//    - It is 1 when imm_sel is not one of the six defined codes; out_imm is still 0 for such entries.
//  Not defined:
//    - Port and storage are absent.
//    - Undefined sel silently yields out_imm=0.
// TESTING
//  addi 0xFFF00093, IMM_I, XLEN=32 -> out_imm=0xFFFFFFFF one cycle after accept, tag echoed
//  sw 0xFE112E23, IMM_S -> 0xFFFFFFFC
//  lui 0x800002B7, IMM_U -> 0x80000000 (XLEN=32) / 0xFFFFFFFF80000000 (XLEN=64)
//  csrrwi 0x300FD073, IMM_Z -> 0x0000001F
//  SKID=1, out_ready=0, 3 back-to-back offers (tags 1,2,3):
//    - first 2 accepted, then in_ready=0
//    - release out_ready -> tags 1,2,3 out in order, no gaps
//  FULL buffer, flush=1 -> next cycle out_valid=0, in_ready=1
//  rst_n=0 mid-stream -> all outputs 0
//  sel=3'b111 with MRV32_IMM_ILLEGAL_EN -> out_imm=0, out_illegal=1

Source files
------------

// File: rtl/mrv32_imm_gen_pipe.sv
// rtl/mrv32_imm_gen_pipe.sv - registered, handshaked MRV32 immediate generator (optional MRV32_IMM_ILLEGAL_EN)
module mrv32_imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag
`ifdef MRV32_IMM_ILLEGAL_EN
  ,
  output logic             out_illegal
`endif
);

  // Format select codes shared with the decoder.
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [2:0] IMM_Z = 3'd5;

`ifdef MRV32_IMM_ILLEGAL_EN
  localparam int ILL_W = 1;
`else
  localparam int ILL_W = 0;
`endif
  // Stored entry layout: {illegal (optional), tag, imm}
  localparam int E_W = XLEN + TAG_W + ILL_W;

  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_x;
  logic [E_W-1:0]  new_entry;
  logic [E_W-1:0]  head_q;
  logic            accept;
  logic            pop;

  // Build the 32-bit immediate; Z is already zero in bit 31, so one sign extension covers all formats.
  always_comb begin
    imm32 = '0;
    case (in_imm_sel)
      IMM_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      IMM_U:   imm32 = {in_instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      IMM_Z:   imm32 = {27'b0, in_instr[19:15]};
      default: imm32 = '0;
    endcase
  end

  assign imm_x = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

`ifdef MRV32_IMM_ILLEGAL_EN
  logic sel_illegal;
  assign sel_illegal = (in_imm_sel > IMM_Z);
  assign new_entry   = {sel_illegal, in_tag, imm_x};
  assign out_illegal = head_q[E_W-1];
`else
  assign new_entry   = {in_tag, imm_x};
`endif

  assign out_imm = head_q[XLEN-1:0];
  assign out_tag = head_q[XLEN +: TAG_W];
  assign accept  = in_valid & in_ready;
  assign pop     = out_valid & out_ready;

  generate
    if (SKID == 1) begin : g_skid
      typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
      state_t         state;
      logic [E_W-1:0] skid_q;

      // Two-entry buffer: head feeds the outputs, skid catches the entry accepted while head is stalled.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          head_q    <= '0;
          skid_q    <= '0;
        end else if (flush) begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end else begin
          case (state)
            EMPTY: begin
              if (accept) begin
                head_q    <= new_entry;
                out_valid <= 1'b1;
                state     <= ONE;
              end
            end
            ONE: begin
              if (accept && pop) begin
                head_q <= new_entry;
              end else if (accept) begin
                skid_q   <= new_entry;
                in_ready <= 1'b0;
                state    <= FULL;
              end else if (pop) begin
                out_valid <= 1'b0;
                state     <= EMPTY;
              end
            end
            FULL: begin
              if (pop) begin
                head_q   <= skid_q;
                in_ready <= 1'b1;
                state    <= ONE;
              end
            end
            default: begin
              state     <= EMPTY;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
            end
          endcase
        end
      end
    end else begin : g_single
      // The flush term keeps upstream unblocked while the stage is being emptied.
      assign in_ready = flush | ~out_valid | out_ready;

      // Single register stage; a new entry may replace the head in the cycle it pops.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          head_q    <= '0;
        end else if (flush) begin
          out_valid <= 1'b0;
        end else if (accept) begin
          head_q    <= new_entry;
          out_valid <= 1'b1;
        end else if (pop) begin
          out_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_mrv32_imm_gen_pipe.sv
// tb/tb_mrv32_imm_gen_pipe.sv - randomized model-checked bench for mrv32_imm_gen_pipe
module tb_mrv32_imm_gen_pipe;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int SKID  = 1;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [2:0] IMM_Z = 3'd5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_imm_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
`ifdef MRV32_IMM_ILLEGAL_EN
  logic             out_illegal;
`endif

  int checks = 0;
  int errors = 0;

  mrv32_imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .SKID(SKID)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_imm_sel (in_imm_sel),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_tag    (out_tag)
`ifdef MRV32_IMM_ILLEGAL_EN
    ,
    .out_illegal(out_illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } entry_t;

  entry_t q[$];
  bit     started     = 0;
  bit     since_reset = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Immediate value from the instruction-set definition, using integer sign extension.
  function automatic logic [XLEN-1:0] ref_imm(input logic [31:0] i, input logic [2:0] s);
    longint v;
    case (s)
      IMM_I:   v = longint'($signed(i[31:20]));
      IMM_S:   v = longint'($signed({i[31:25], i[11:7]}));
      IMM_B:   v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      IMM_U:   v = longint'($signed({i[31:12], 12'h000}));
      IMM_J:   v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      IMM_Z:   v = longint'({59'd0, i[19:15]});
      default: v = 0;
    endcase
    return v[XLEN-1:0];
  endfunction

  // Reference model: a FIFO of at most 2 (SKID=1) or 1 (SKID=0) entries.
  always @(posedge clk) begin
    bit rdy, acc, pop;
    entry_t e;
    started = 1;
    if (!rst_n || flush) begin
      q.delete();
      if (!rst_n) since_reset = 1;
    end else begin
      rdy = (SKID == 1) ? (q.size() < 2) : (q.size() == 0 || out_ready);
      pop = (q.size() > 0) && out_ready;
      acc = in_valid && rdy;
      if (pop) void'(q.pop_front());
      if (acc) begin
        e.imm = ref_imm(in_instr, in_imm_sel);
        e.tag = in_tag;
        e.ill = (in_imm_sel > IMM_Z);
        q.push_back(e);
        since_reset = 0;
      end
    end
  end

  // Every cycle: DUT outputs must match the model.
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", out_valid, (q.size() > 0));
      if (SKID == 1) chk("in_ready", in_ready, (q.size() < 2));
      if (q.size() > 0) begin
        chk("out_imm", out_imm, q[0].imm);
        chk("out_tag", out_tag, q[0].tag);
`ifdef MRV32_IMM_ILLEGAL_EN
        chk("out_illegal", out_illegal, q[0].ill);
`endif
      end else if (since_reset) begin
        chk("reset_imm", out_imm, 0);
        chk("reset_tag", out_tag, 0);
      end
    end
  end

  task automatic idle();
    in_valid = 0; flush = 0;
  endtask

  // Offer one entry to an empty stage with out_ready=1 and check the result one cycle later.
  task automatic send_one(input string name, input logic [31:0] instr, input logic [2:0] sel,
                          input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp);
    in_valid = 1; in_instr = instr; in_imm_sel = sel; in_tag = tag; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_imm"}, out_imm, exp);
    chk({name, "_tag"}, out_tag, tag);
    @(negedge clk);
  endtask

  initial begin
    logic [TAG_W-1:0] seen [3];
    rst_n = 0; idle(); out_ready = 0; in_instr = 0; in_imm_sel = 0; in_tag = 0;

    // Pin the reference model itself.
    chk("ref_addi", ref_imm(32'hFFF00093, IMM_I), 32'hFFFFFFFF);
    chk("ref_sw",   ref_imm(32'hFE112E23, IMM_S), 32'hFFFFFFFC);
    chk("ref_lui",  ref_imm(32'h800002B7, IMM_U), 32'h80000000);
    chk("ref_csr",  ref_imm(32'h300FD073, IMM_Z), 32'h0000001F);
    chk("ref_beq",  ref_imm(32'h80000063, IMM_B), 32'hFFFFF000);
    chk("ref_jal",  ref_imm(32'h800000EF, IMM_J), 32'hFFF00000);
    chk("ref_bad",  ref_imm(32'hFFFFFFFF, 3'b111), 32'h0);

    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1;
    @(negedge clk);

    send_one("addi", 32'hFFF00093, IMM_I, 5'd7, 32'hFFFFFFFF);
    send_one("sw",   32'hFE112E23, IMM_S, 5'd9, 32'hFFFFFFFC);
    send_one("lui",  32'h800002B7, IMM_U, 5'd3, 32'h80000000);
    send_one("csr",  32'h300FD073, IMM_Z, 5'd30, 32'h0000001F);
    send_one("bad",  32'hFFFFFFFF, 3'b111, 5'd1, 32'h0);

    // Skid fill: three offers with downstream stalled.
    out_ready = 0; in_valid = 1; in_instr = 32'h00100093; in_imm_sel = IMM_I; in_tag = 5'd1;
    @(negedge clk);
    chk("skid_ready1", in_ready, 1);
    in_tag = 5'd2; in_instr = 32'h00200093;
    @(negedge clk);
    chk("skid_ready2", in_ready, 0);
    in_tag = 5'd3; in_instr = 32'h00300093;
    @(negedge clk);
    chk("skid_ready3", in_ready, 0);
    out_ready = 1;
    seen[0] = out_tag;
    @(negedge clk);
    seen[1] = out_tag;
    chk("skid_valid2", out_valid, 1);
    @(negedge clk);
    seen[2] = out_tag;
    chk("skid_valid3", out_valid, 1);
    in_valid = 0;
    chk("skid_tag1", seen[0], 1);
    chk("skid_tag2", seen[1], 2);
    chk("skid_tag3", seen[2], 3);
    @(negedge clk);
    chk("skid_drained", out_valid, 0);

    // Flush from a full buffer, with a new offer in the flush cycle.
    out_ready = 0; in_valid = 1; in_instr = 32'hFFF00093; in_imm_sel = IMM_I; in_tag = 5'd4;
    repeat (2) @(negedge clk);
    chk("full_ready", in_ready, 0);
    flush = 1; in_tag = 5'd5;
    @(negedge clk);
    flush = 0; in_valid = 0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    @(negedge clk);
    chk("flush_dropped", out_valid, 0);

    // Reset in the middle of a stream.
    in_valid = 1; in_instr = 32'h800002B7; in_imm_sel = IMM_U; in_tag = 5'd17;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; in_valid = 0;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_imm", out_imm, 0);
    chk("mrst_tag", out_tag, 0);
    chk("mrst_ready", in_ready, 1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      in_instr   = $urandom;
      in_imm_sel = 3'($urandom_range(0, 7));
      in_tag     = TAG_W'($urandom);
      flush      = ($urandom_range(0, 31) == 0);
      rst_n      = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    rst_n = 1; idle(); out_ready = 1;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
